// File: rtl/md_if.sv
// Issue/result bundle between the EX-stage multiply/divide unit and its issuer.
// The issuer drives Start/MDOp/A1/A2 and observes Busy plus the Hi/Lo pair.
interface md_if;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A1;
  logic [31:0] A2;
  logic        Busy;
  logic [31:0] Hi;
  logic [31:0] Lo;

  modport master (output Start, MDOp, A1, A2, input Busy, Hi, Lo);
  modport slave  (input Start, MDOp, A1, A2, output Busy, Hi, Lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the Hi/Lo register pair.
// Results are computed at issue, held pending, and committed when the countdown expires.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  md
);
  typedef enum logic [2:0] {
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110
  } md_op_e;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_op_e      op;
  logic [CW-1:0] cnt;
  logic [31:0] hi_q, lo_q, ph, pl;
  logic        pend_wr;

  logic [63:0] prod_s, prod_u;
  logic        sgn_div;
  logic [31:0] a_mag, b_mag, da, db, uq, ur, quot, rem;

  assign op = md_op_e'(md.MDOp);

  // Signed division runs on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of overflowing.
  always_comb begin
    prod_u  = {32'd0, md.A1} * {32'd0, md.A2};
    prod_s  = {{32{md.A1[31]}}, md.A1} * {{32{md.A2[31]}}, md.A2};
    sgn_div = (op == OP_DIV);
    a_mag   = md.A1[31] ? (32'd0 - md.A1) : md.A1;
    b_mag   = md.A2[31] ? (32'd0 - md.A2) : md.A2;
    da      = sgn_div ? a_mag : md.A1;
    db      = sgn_div ? b_mag : md.A2;
    if (db == 32'd0) db = 32'd1;
    uq      = da / db;
    ur      = da % db;
    quot    = (sgn_div && (md.A1[31] ^ md.A2[31])) ? (32'd0 - uq) : uq;
    rem     = (sgn_div && md.A1[31]) ? (32'd0 - ur) : ur;
  end

  // NOTE: Busy derives only from the registered counter, never from Start,
  // so the hazard unit sees no combinational path from issue to stall.
  assign md.Busy = (cnt != '0);
  assign md.Hi   = hi_q;
  assign md.Lo   = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      ph      <= '0;
      pl      <= '0;
      pend_wr <= 1'b0;
      cnt     <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1) && pend_wr) begin
        hi_q <= ph;
        lo_q <= pl;
      end
    end else if (md.Start) begin
      case (op)
        OP_MULT: begin
          {ph, pl} <= prod_s;
          pend_wr  <= 1'b1;
          cnt      <= CW'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {ph, pl} <= prod_u;
          pend_wr  <= 1'b1;
          cnt      <= CW'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          ph      <= rem;
          pl      <= quot;
          pend_wr <= (md.A2 != 32'd0);
          cnt     <= CW'(DIV_CYCLES);
        end
        OP_MTHI: hi_q <= md.A1;
        OP_MTLO: lo_q <= md.A1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected Hi/Lo pairs are queued at issue and
// compared by a monitor whenever Busy falls.
module tb_md_unit;
  localparam logic [2:0] MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011,
                         DIVU = 3'b100, MTHI = 3'b101, MTLO = 3'b110;

  logic clk = 1'b0;
  logic reset;
  md_if bus ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb[$];
  logic prev_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Busy falling edge presents a committed Hi/Lo pair.
  always @(negedge clk) begin
    if (prev_busy && !bus.Busy) begin
      if (sb.size() == 0) check("unexpected_completion", {bus.Hi, bus.Lo}, 64'hx);
      else check("hilo_result", {bus.Hi, bus.Lo}, sb.pop_front());
    end
    prev_busy = bus.Busy;
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a1, input logic [31:0] a2);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = op; bus.A1 = a1; bus.A2 = a2;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  // Called at the first negedge after the accept edge; counts cycles with Busy high.
  task automatic wait_idle(input string name, input int exp_cycles);
    int n = 0;
    while (bus.Busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check(name, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    reset = 1'b1;
    bus.Start = 1'b0; bus.MDOp = 3'b000; bus.A1 = '0; bus.A2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_state", {31'd0, bus.Busy, bus.Hi, bus.Lo}, 97'd0);

    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
    issue(MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle("mult_busy", 5);

    sb.push_back({32'hFFFFFFFE, 32'h00000001});
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle("multu_busy", 5);

    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_busy", 10);

    sb.push_back({32'd1, 32'd3});
    issue(DIVU, 32'd7, 32'd2);
    wait_idle("divu_busy", 10);

    sb.push_back({32'd0, 32'h80000000});
    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_ovf_busy", 10);

    // mthi then mtlo on consecutive edges
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = MTHI; bus.A1 = 32'h12345678;
    @(negedge clk);
    check("mthi_busy", {63'd0, bus.Busy}, 64'd0);
    check("mthi_hi", {32'd0, bus.Hi}, {32'd0, 32'h12345678});
    bus.MDOp = MTLO; bus.A1 = 32'h9ABCDEF0;
    @(negedge clk);
    bus.Start = 1'b0;
    check("mtlo_busy", {63'd0, bus.Busy}, 64'd0);
    check("mt_hilo", {bus.Hi, bus.Lo}, {32'h12345678, 32'h9ABCDEF0});

    sb.push_back({32'h12345678, 32'h9ABCDEF0});
    issue(DIV, 32'd55, 32'd0);
    wait_idle("div0_busy", 10);

    // mult with an ignored mtlo mid-flight and Start held across the completion edge
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFE0C});
    sb.push_back({32'd2, 32'd14});
    issue(MULT, 32'd100, 32'hFFFFFFFB);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = MTLO; bus.A1 = 32'hDEADBEEF; bus.A2 = 32'h0;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    bus.Start = 1'b1; bus.MDOp = DIVU; bus.A1 = 32'd100; bus.A2 = 32'd7;
    @(negedge clk);
    check("completion_edge_ignored", {63'd0, bus.Busy}, 64'd0);
    @(negedge clk);
    bus.Start = 1'b0;
    wait_idle("next_cycle_accept", 10);

    // reset in the middle of a divide
    sb.push_back(64'd0);
    issue(DIV, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid_busy", {63'd0, bus.Busy}, 64'd0);
    check("reset_mid_hilo", {bus.Hi, bus.Lo}, 64'd0);
    repeat (12) @(negedge clk);
    check("no_late_write", {31'd0, bus.Busy, bus.Hi, bus.Lo}, 97'd0);

    sb.push_back({32'd0, 32'd42});
    issue(MULT, 32'd6, 32'd7);
    wait_idle("post_reset_mult_busy", 5);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit: the producer of the Hi/Lo register pair that the ALU reads through its Hi/Lo inputs for mfhi/mflo.
- Executes mult, multu, div and divu over a fixed multi-cycle latency, plus single-cycle mthi and mtlo.
- Sits in the EX stage beside the ALU.
- Busy goes to the hazard unit, which stalls any md or mf/mt instruction while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for mult/multu (≥1)
- DIV_CYCLES, 10, cycles Busy stays high for div/divu (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Start  input  1  issue strobe, sampled at rising edge of clk
- MDOp  input  3  001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo; others are no-ops
- A1  input  32  rs operand (multiplicand / dividend / mthi-mtlo source)
- A2  input  32  rt operand (multiplier / divisor)
- Busy  output  1  high while a mult/div is in flight
- Hi  output  32  Hi register
- Lo  output  32  Lo register

Behaviour:
- Reset (sync, highest priority):
  - Hi=0, Lo=0, Busy=0, cycle counter=0.
  - Any in-flight result is discarded; operands latched before reset are never written.
- Idle = counter==0. Busy = (counter!=0), registered only; Start does not feed Busy combinationally.
- Accept: at an edge with Start=1, Busy=0 and a valid MDOp:
  - mult/multu/div/divu:
    - compute the 64-bit result into pending registers PH/PL;
    - load counter with MULT_CYCLES or DIV_CYCLES;
    - Hi and Lo are unchanged.
  - mthi: Hi←A1 at this edge. Lo unchanged, Busy stays 0.
  - mtlo: Lo←A1 at this edge. Hi unchanged, Busy stays 0.
- Start while Busy=1: ignored entirely; no operand latch and no Hi/Lo write. The hazard unit guarantees this does not occur; the unit must still be safe if it does.
- Countdown:
  - Each edge with counter>0 decrements it.
  - At the edge where counter goes 1→0: Hi←PH, Lo←PL.
  - Busy is therefore high for exactly N cycles after the accept edge. New Hi/Lo are visible in the first cycle with Busy=0.
- Arithmetic:
  - mult: signed 32×32→64; Hi=bits[63:32], Lo=bits[31:0].
  - multu: same split, unsigned operands.
  - div: Lo=quotient truncated toward zero; Hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 by 0xFFFFFFFF: Lo=0x80000000, Hi=0.
  - Divide by zero (A2=0, div or divu): runs full DIV_CYCLES; at completion Hi and Lo keep their prior values.
- Operands are captured at the accept edge. A1/A2 changes during Busy have no effect.
- Back-to-back: Start may be accepted on the same edge at which the counter reaches 0? No. That edge still sees Busy=1, so Start is ignored. The next op is accepted one cycle later, once Busy=0.
- Reset mid-operation: Busy=0 the next cycle and Hi/Lo=0; a Start in the following cycle is accepted normally.
- Hi/Lo are never modified other than by reset, mthi/mtlo, or completion of a mult/div.

Test Plan:
- Reset, then mult A1=0xFFFFFFFE (−2), A2=3 → Busy high 5 cycles; then Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
- multu A1=0xFFFFFFFF, A2=0xFFFFFFFF → after 5 cycles Hi=0xFFFFFFFE, Lo=0x00000001.
- div A1=0xFFFFFFF9 (−7), A2=2 → Busy 10 cycles; Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. divu A1=7, A2=2 → Lo=3, Hi=1.
- mthi 0x12345678, then mtlo 0x9ABCDEF0 on consecutive cycles → Busy stays 0; Hi/Lo hold those values. Then div by A2=0 → Busy 10 cycles; Hi/Lo unchanged.
- During a mult, pulse Start with MDOp=mtlo, A1=0xDEADBEEF at cycle 2 → ignored; final Lo equals the mult result. Start asserted on the completion edge is also ignored and is accepted on the next cycle.
- Start div, assert reset at cycle 4 → next cycle Busy=0, Hi=Lo=0. No delayed write occurs at the original completion time; mult 6×7 started afterwards gives Lo=42, Hi=0.
